// File: rtl/wb_write_queue_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wbq_pkg
// Purpose  : Shared constants and entry type for the write-back request queue.
// Revision : 1.0
// ============================================================================
package wbq_pkg;
    localparam int REG_IDX_W  = 5;
    localparam int DEF_DATA_W = 64;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [REG_IDX_W-1:0]  rd;
        logic [DEF_DATA_W-1:0] data;
    } wbq_entry_t;

    function automatic logic is_zero_reg(input logic [REG_IDX_W-1:0] r);
        return r == ZERO_REG;
    endfunction
endpackage
`default_nettype wire

// File: rtl/wb_write_queue_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_write_queue_if
// Purpose  : Write-back request handshake, decoder drive and forwarding lookup.
// Revision : 1.0
// ============================================================================
interface wb_write_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
);
    import wbq_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [REG_IDX_W-1:0]       in_reg;
    logic [DATA_W-1:0]          in_data;
    logic                       hold;
    logic [REG_IDX_W-1:0]       WriteReg;
    logic                       RegWrite;
    logic [DATA_W-1:0]          WriteData;
    logic [$clog2(DEPTH):0]     count;
    logic [REG_IDX_W-1:0]       fwd_reg;
    logic                       fwd_hit;
    logic [DATA_W-1:0]          fwd_data;

    modport master (
        output in_valid, in_reg, in_data, hold, fwd_reg,
        input  in_ready, WriteReg, RegWrite, WriteData, count, fwd_hit, fwd_data
    );

    modport slave (
        input  in_valid, in_reg, in_data, hold, fwd_reg,
        output in_ready, WriteReg, RegWrite, WriteData, count, fwd_hit, fwd_data
    );
endinterface
`default_nettype wire

// File: rtl/wb_write_queue_lookup.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wbq_lookup
// Purpose  : Youngest-first match of a register index over pending entries
//            (used only when WBQ_FWD_EN is defined).
// Revision : 1.0
// ============================================================================
module wbq_lookup
    import wbq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [REG_IDX_W-1:0]     entry_reg_i  [DEPTH],
    input  logic [DATA_W-1:0]        entry_data_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] tail_i,
    input  logic [$clog2(DEPTH):0]   count_i,
    input  logic [REG_IDX_W-1:0]     fwd_reg_i,
    output logic                     fwd_hit_o,
    output logic [DATA_W-1:0]        fwd_data_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk backwards from the newest entry; the first valid match wins.
    always_comb begin
        found      = 1'b0;
        idx        = '0;
        fwd_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail_i - PTR_W'(k + 1);
            if (!found && (k < int'(count_i)) && (entry_reg_i[idx] == fwd_reg_i)
                && !is_zero_reg(fwd_reg_i)) begin
                found      = 1'b1;
                fwd_data_o = entry_data_i[idx];
            end
        end
        fwd_hit_o = found;
    end
endmodule
`default_nettype wire

// File: rtl/wb_write_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_write_queue
// Purpose  : In-order register-write queue feeding the 5-to-32 write decoder;
//            XZR writes dropped at entry. WBQ_FWD_EN adds a forwarding lookup.
// Revision : 1.0
// ============================================================================
module wb_write_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic            clk,
    input  logic            reset_n,
    wb_write_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [REG_IDX_W-1:0] reg_q  [DEPTH];
    logic [DATA_W-1:0]    data_q [DEPTH];
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 not_empty;
    logic                 accept;
    logic                 store;
    logic                 drain;

    assign not_empty    = (count_q != '0);
    assign bus.in_ready = (count_q < FULL_CNT);
    assign accept       = bus.in_valid && bus.in_ready;
    // XZR requests complete the handshake but never occupy a slot.
    assign store        = accept && !is_zero_reg(bus.in_reg);
    assign drain        = not_empty && !bus.hold;

    assign bus.RegWrite  = drain;
    assign bus.WriteReg  = not_empty ? reg_q[head_q]  : '0;
    assign bus.WriteData = not_empty ? data_q[head_q] : '0;
    assign bus.count     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (store) tail_d = tail_q + PTR_W'(1);
        if (drain) head_d = head_q + PTR_W'(1);
        case ({store, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is left uninitialised; pointer reset alone empties the queue.
    always_ff @(posedge clk) begin
        if (store) begin
            reg_q[tail_q]  <= bus.in_reg;
            data_q[tail_q] <= bus.in_data;
        end
    end

`ifdef WBQ_FWD_EN
    wbq_lookup #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_lookup (
        .entry_reg_i  (reg_q),
        .entry_data_i (data_q),
        .tail_i       (tail_q),
        .count_i      (count_q),
        .fwd_reg_i    (bus.fwd_reg),
        .fwd_hit_o    (bus.fwd_hit),
        .fwd_data_o   (bus.fwd_data)
    );
`else
    assign bus.fwd_hit  = 1'b0;
    assign bus.fwd_data = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_queue
// Purpose  : Directed vector bench for wb_write_queue (DEPTH 4, DATA_W 64).
// Revision : 1.0
// ============================================================================
module tb_wb_write_queue;
`ifdef WBQ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_write_queue_if #(.DEPTH(4), .DATA_W(64)) bus ();

    wb_write_queue #(.DEPTH(4), .DATA_W(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        rstn;
        logic        valid;
        logic [4:0]  rg;
        logic [63:0] data;
        logic        hold;
        logic        e_ready;
        logic        e_rw;
        logic [4:0]  e_reg;
        logic [63:0] e_data;
        logic [2:0]  e_count;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rstn, input logic valid, input logic [4:0] rg,
                                input logic [63:0] data, input logic hold,
                                input logic e_ready, input logic e_rw, input logic [4:0] e_reg,
                                input logic [63:0] e_data, input logic [2:0] e_count);
        vec_t v;
        v.rstn = rstn; v.valid = valid; v.rg = rg; v.data = data; v.hold = hold;
        v.e_ready = e_ready; v.e_rw = e_rw; v.e_reg = e_reg; v.e_data = e_data;
        v.e_count = e_count;
        return v;
    endfunction

    task automatic step(input logic rstn, input logic valid, input logic [4:0] rg,
                        input logic [63:0] data, input logic hold, input logic [4:0] fwd);
        @(negedge clk);
        reset_n      = rstn;
        bus.in_valid = valid;
        bus.in_reg   = rg;
        bus.in_data  = data;
        bus.hold     = hold;
        bus.fwd_reg  = fwd;
        #1;
    endtask

    task automatic check_out(input string name, input logic er, input logic erw,
                             input logic [4:0] ereg, input logic [63:0] ed, input logic [2:0] ec);
        n_cmp++;
        if (bus.in_ready !== er || bus.RegWrite !== erw || bus.WriteReg !== ereg ||
            bus.WriteData !== ed || bus.count !== ec) begin
            n_err++;
            $display("FAIL %s: got ready=%0b rw=%0b reg=%0d data=%h count=%0d, want ready=%0b rw=%0b reg=%0d data=%h count=%0d",
                     name, bus.in_ready, bus.RegWrite, bus.WriteReg, bus.WriteData, bus.count,
                     er, erw, ereg, ed, ec);
        end
    endtask

    task automatic check_fwd(input string name, input logic ehit, input logic [63:0] ed);
        logic        want_hit;
        logic [63:0] want_data;
        want_hit  = FWD & ehit;
        want_data = FWD ? ed : 64'h0;
        n_cmp++;
        if (bus.fwd_hit !== want_hit || bus.fwd_data !== want_data) begin
            n_err++;
            $display("FAIL %s: got hit=%0b data=%h, want hit=%0b data=%h",
                     name, bus.fwd_hit, bus.fwd_data, want_hit, want_data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Each row: inputs for this cycle, outputs expected before the next edge.
        vecs.push_back(mk(1, 0, 0,  64'h0,   0, 1, 0, 0, 64'h0,  0));
        vecs.push_back(mk(1, 1, 5,  64'hA5,  0, 1, 0, 0, 64'h0,  0));
        vecs.push_back(mk(1, 0, 0,  64'h0,   0, 1, 1, 5, 64'hA5, 1));
        vecs.push_back(mk(1, 0, 0,  64'h0,   0, 1, 0, 0, 64'h0,  0));
        // Fill under hold, then release
        vecs.push_back(mk(1, 1, 1,  64'h11,  1, 1, 0, 0, 64'h0,  0));
        vecs.push_back(mk(1, 1, 2,  64'h22,  1, 1, 0, 1, 64'h11, 1));
        vecs.push_back(mk(1, 1, 3,  64'h33,  1, 1, 0, 1, 64'h11, 2));
        vecs.push_back(mk(1, 1, 4,  64'h44,  1, 1, 0, 1, 64'h11, 3));
        vecs.push_back(mk(1, 1, 9,  64'h99,  1, 0, 0, 1, 64'h11, 4));
        vecs.push_back(mk(1, 1, 9,  64'h99,  0, 0, 1, 1, 64'h11, 4));
        vecs.push_back(mk(1, 0, 0,  64'h0,   0, 1, 1, 2, 64'h22, 3));
        vecs.push_back(mk(1, 0, 0,  64'h0,   0, 1, 1, 3, 64'h33, 2));
        vecs.push_back(mk(1, 0, 0,  64'h0,   0, 1, 1, 4, 64'h44, 1));
        vecs.push_back(mk(1, 0, 0,  64'h0,   0, 1, 0, 0, 64'h0,  0));
        // XZR write is swallowed
        vecs.push_back(mk(1, 1, 31, 64'hFF,  0, 1, 0, 0, 64'h0,  0));
        vecs.push_back(mk(1, 0, 0,  64'h0,   0, 1, 0, 0, 64'h0,  0));
        // Streaming accept + drain, regs 0..9
        vecs.push_back(mk(1, 1, 0,  64'h100, 0, 1, 0, 0, 64'h0,  0));
        for (int i = 1; i < 10; i++)
            vecs.push_back(mk(1, 1, 5'(i), 64'h100 + 64'(i), 0, 1, 1, 5'(i - 1), 64'h100 + 64'(i - 1), 1));
        vecs.push_back(mk(1, 0, 0,  64'h0,   0, 1, 1, 9, 64'h109, 1));
        vecs.push_back(mk(1, 0, 0,  64'h0,   0, 1, 0, 0, 64'h0,  0));
        // Reset with three pending entries and a request in flight
        vecs.push_back(mk(1, 1, 10, 64'hA,   1, 1, 0, 0,  64'h0, 0));
        vecs.push_back(mk(1, 1, 11, 64'hB,   1, 1, 0, 10, 64'hA, 1));
        vecs.push_back(mk(1, 1, 12, 64'hC,   1, 1, 0, 10, 64'hA, 2));
        vecs.push_back(mk(0, 1, 13, 64'hD,   0, 1, 1, 10, 64'hA, 3));
        vecs.push_back(mk(1, 0, 0,  64'h0,   0, 1, 0, 0,  64'h0, 0));
        vecs.push_back(mk(1, 0, 0,  64'h0,   0, 1, 0, 0,  64'h0, 0));

        bus.in_valid = 1'b0;
        bus.in_reg   = '0;
        bus.in_data  = '0;
        bus.hold     = 1'b0;
        bus.fwd_reg  = '0;
        reset_n      = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            step(vecs[i].rstn, vecs[i].valid, vecs[i].rg, vecs[i].data, vecs[i].hold, 5'd0);
            check_out($sformatf("row%0d", i), vecs[i].e_ready, vecs[i].e_rw, vecs[i].e_reg,
                      vecs[i].e_data, vecs[i].e_count);
        end
        check_fwd("fwd_idle", 1'b0, 64'h0);

        // Forwarding: same-cycle enqueue invisible, youngest match wins, XZR never hits
        step(1, 1, 7, 64'h1, 1, 5'd7);
        check_fwd("fwd_enq_invisible", 1'b0, 64'h0);
        step(1, 1, 7, 64'h2, 1, 5'd7);
        check_fwd("fwd_one_pending", 1'b1, 64'h1);
        step(1, 1, 3, 64'h33, 1, 5'd7);
        check_fwd("fwd_youngest", 1'b1, 64'h2);
        step(1, 0, 0, 64'h0, 1, 5'd7);
        check_out("fwd_held", 1, 0, 7, 64'h1, 3);
        check_fwd("fwd_youngest3", 1'b1, 64'h2);
        bus.fwd_reg = 5'd31; #1;
        check_fwd("fwd_xzr", 1'b0, 64'h0);
        bus.fwd_reg = 5'd3; #1;
        check_fwd("fwd_reg3", 1'b1, 64'h33);
        bus.fwd_reg = 5'd9; #1;
        check_fwd("fwd_miss", 1'b0, 64'h0);
        step(1, 0, 0, 64'h0, 0, 5'd7);
        check_out("fwd_drain1", 1, 1, 7, 64'h1, 3);
        check_fwd("fwd_drain1_hit", 1'b1, 64'h2);
        step(1, 0, 0, 64'h0, 0, 5'd7);
        check_out("fwd_drain2", 1, 1, 7, 64'h2, 2);
        check_fwd("fwd_head_draining", 1'b1, 64'h2);
        step(1, 0, 0, 64'h0, 0, 5'd7);
        check_fwd("fwd_gone", 1'b0, 64'h0);
        bus.fwd_reg = 5'd3; #1;
        check_fwd("fwd_last_head", 1'b1, 64'h33);
        step(1, 0, 0, 64'h0, 0, 5'd3);
        check_out("fwd_empty", 1, 0, 0, 64'h0, 0);
        check_fwd("fwd_empty_miss", 1'b0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
